// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b subtractor, one bit per clock, LSB first
// Operands and results move over valid/ready handshakes; one full-subtractor cell is reused.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             br_q,     br_d;
    logic             borrow_q, borrow_d;

    logic a_bit;
    logic b_bit;
    logic d_bit;
    logic br_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        diff_d    = diff_q;
        cnt_d     = cnt_q;
        br_d      = br_q;
        borrow_d  = borrow_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        // Full-subtractor cell on the bit selected by the counter.
        a_bit   = a_q[cnt_q];
        b_bit   = b_q[cnt_q];
        d_bit   = a_bit ^ b_bit ^ br_q;
        br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    br_d    = 1'b0;
                    diff_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d[cnt_q] = d_bit;
                br_d          = br_next;
                // Counter is parked at zero on the last bit so a power-of-2 WIDTH never wraps it.
                if (cnt_q == LAST) begin
                    borrow_d = br_next;
                    cnt_d    = '0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH = 4)
// Directed vector table, hand-written corner sequences, exhaustive and random checks against arithmetic.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;

    int errors  = 0;
    int checks  = 0;
    int results = 0;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] exp_diff;
        logic         exp_borrow;
        int           stalls;
    } vec_t;

    typedef struct {
        int pa;
        int pb;
    } pair_t;

    pair_t pending[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_noise();
        in_valid = 1'($urandom);
        a        = W'($urandom);
        b        = W'($urandom);
    endtask

    // Called at a falling edge in IDLE; returns at the falling edge after the accept edge.
    task automatic start(input logic [W-1:0] av, input logic [W-1:0] bv);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        @(posedge clk);
        @(negedge clk);
        drive_noise();
        chk("in_ready_run", 32'(in_ready), 32'd0);
    endtask

    task automatic wait_result();
        int  lat;
        bit  seen;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            drive_noise();
        end
        if (!seen) chk("result_timeout", 32'd0, 32'd1);
        else       chk("latency", 32'(lat), 32'(W));
    endtask

    task automatic check_result(input logic [W-1:0] ed, input logic eb, input int stalls);
        chk("diff", 32'(diff), 32'(ed));
        chk("borrow", 32'(borrow), 32'(eb));
        chk("in_ready_done", 32'(in_ready), 32'd0);
        for (int i = 0; i < stalls; i++) begin
            drive_noise();
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_diff", 32'(diff), 32'(ed));
            chk("stall_borrow", 32'(borrow), 32'(eb));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        results++;
        chk("no_duplicate", 32'(out_valid), 32'd0);
        chk("in_ready_after", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int stalls);
        pair_t        p;
        int           ed;
        logic [W-1:0] ed_w;
        pending.push_back('{pa: int'(av), pb: int'(bv)});
        start(av, bv);
        wait_result();
        p    = pending.pop_front();
        ed   = ((p.pa - p.pb) % (1 << W) + (1 << W)) % (1 << W);
        ed_w = W'(ed);
        check_result(ed_w, (p.pa < p.pb), stalls);
        pop();
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{va: 4'd9,  vb: 4'd3,  exp_diff: 4'd6,  exp_borrow: 1'b0, stalls: 0};
        vecs[1] = '{va: 4'd3,  vb: 4'd9,  exp_diff: 4'd10, exp_borrow: 1'b1, stalls: 1};
        vecs[2] = '{va: 4'd15, vb: 4'd15, exp_diff: 4'd0,  exp_borrow: 1'b0, stalls: 0};
        vecs[3] = '{va: 4'd0,  vb: 4'd1,  exp_diff: 4'd15, exp_borrow: 1'b1, stalls: 2};
        vecs[4] = '{va: 4'd0,  vb: 4'd0,  exp_diff: 4'd0,  exp_borrow: 1'b0, stalls: 0};
        vecs[5] = '{va: 4'd8,  vb: 4'd15, exp_diff: 4'd9,  exp_borrow: 1'b1, stalls: 0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            start(vecs[i].va, vecs[i].vb);
            wait_result();
            check_result(vecs[i].exp_diff, vecs[i].exp_borrow, vecs[i].stalls);
            pop();
        end

        // Back-pressure, then a transfer edge with in_valid already high must not also accept.
        start(4'd12, 4'd5);
        wait_result();
        check_result(4'd7, 1'b0, 6);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 4'd1;
        b         = 4'd0;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_single_transfer", 32'(out_valid), 32'd0);
        chk("bp_idle_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_accepted", 32'(in_ready), 32'd0);
        wait_result();
        check_result(4'd1, 1'b0, 0);
        pop();

        // Asynchronous reset two edges into RUN.
        start(4'd7, 4'd3);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_diff", 32'(diff), 32'd0);
        chk("mid_rst_borrow", 32'(borrow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_no_result", 32'(out_valid), 32'd0);
        start(4'd5, 4'd2);
        wait_result();
        check_result(4'd3, 1'b0, 0);
        pop();

        results = 0;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                run_op(W'(ai), W'(bi), int'($urandom_range(0, 3)));
            end
        end
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 4)));
        end
        chk("result_count", 32'(results), 32'd296);
        chk("queue_empty", 32'(pending.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d expected %0d", 0, 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor. It computes diff = a - b (mod 2^WIDTH) and a borrow-out by processing one bit per clock, LSB first, using a single full-subtractor cell.
- It is the inverse-direction counterpart to the team's combinational adder blocks and uses the same WIDTH-parameterised operand interface.
- Operands are accepted and results are delivered over valid/ready handshakes, so the block can sit in a pipelined datapath.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range is 1 or more.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a/b operands are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  diff/borrow are valid.
- out_ready  input  1  downstream accepts the result.
- diff  output  WIDTH  a - b mod 2^WIDTH.
- borrow  output  1  1 when a < b (unsigned).

Behaviour:
- Reset (asserted asynchronously, takes effect immediately, including mid-operation):
  - state = IDLE; internal a/b shift registers, bit counter and borrow register are all 0.
  - Outputs: diff = 0, borrow = 0, out_valid = 0, in_ready = 1.
  - A partial operation is discarded; no result is ever produced for it.
- FSM states: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On an edge with in_valid = 1: latch a and b, set cnt = 0, clear the borrow register, clear diff, go to RUN.
  - With in_valid = 0 the state holds.
- RUN:
  - in_ready = 0, out_valid = 0; in_valid and operand changes are ignored.
  - Each edge processes bit i = cnt:
    - d = a[i] ^ b[i] ^ br
    - br_next = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br)
  - d is written into diff[i] (or shifted in MSB-side and right-shifted; final bit order must match a - b). br is updated and cnt increments.
  - On the edge that processes bit WIDTH-1: borrow = br_next, go to DONE.
- Latency:
  - Exactly WIDTH RUN edges.
  - If operands are accepted on edge N, out_valid is 1 after edge N+WIDTH.
  - Minimum throughput is one operation per WIDTH+2 cycles.
- DONE:
  - out_valid = 1, in_ready = 0.
  - diff and borrow are stable and must not change while out_valid = 1 and out_ready = 0 (back-pressure of any length).
  - On an edge with out_ready = 1: go to IDLE, out_valid drops.
  - No new operand is accepted on that same edge; the in_ready handshake resumes the following cycle.
- diff/borrow after a transfer: they hold their last value in IDLE until the next accept clears diff. They are don't-care for the bench whenever out_valid = 0.
- Arithmetic: unsigned. borrow = 1 iff a < b. diff wraps modulo 2^WIDTH (e.g. WIDTH = 4: 3 - 9 gives diff = 4'b1010, borrow = 1).
- Simultaneous events:
  - in_valid asserted outside IDLE has no effect.
  - out_ready asserted outside DONE has no effect.
  - rst overrides everything.
- WIDTH = 1: RUN lasts exactly one edge.
- Counter width: $clog2(WIDTH) bits, minimum 1. The counter must not overflow for WIDTH a power of 2.

Test Plan:
- Basic: WIDTH = 4, a = 9, b = 3, in_valid pulse, out_ready = 1.
  - diff = 6, borrow = 0.
  - out_valid rises exactly 4 edges after the accept edge.
  - in_ready is 0 during RUN/DONE.
- Underflow: a = 3, b = 9 -> diff = 4'b1010, borrow = 1. Edge cases: a = b = 15 -> diff = 0, borrow = 0; a = 0, b = 1 -> diff = 15, borrow = 1.
- Back-pressure: a = 12, b = 5, out_ready held 0 for 6 cycles with in_valid = 1 and changing a/b.
  - diff = 7 and borrow = 0 stay constant, out_valid stays 1, in_ready stays 0.
  - After out_ready = 1, exactly one transfer occurs and the next operand is taken in IDLE.
- Reset mid-operation: assert rst 2 cycles into RUN.
  - Immediately: out_valid = 0, in_ready = 1, diff = 0, borrow = 0.
  - A following a = 5, b = 2 yields diff = 3 with full WIDTH latency.
- Exhaustive: all 256 {a,b} pairs back-to-back with randomised out_ready stalls.
  - Each result is compared against (a - b) mod 16 and the borrow against (a < b).
  - Zero mismatches are allowed, and no result may be dropped or duplicated.
